// File: rtl/trigger_interval_meter.sv
// trigger_interval_meter
//   Measures the number of CLK cycles between successive one-cycle trigger
//   strobes. The first trigger after arming opens an interval. Each later
//   trigger closes the current interval and opens the next, so back-to-back
//   intervals are measured with no gap. An interval that reaches 2^WIDTH-1
//   cycles without a trigger raises an overflow strobe and re-arms.
//
// Ports
//   CLK           system clock, rising edge
//   RESET         asynchronous, active-high reset
//   ENABLE_IN     measurement enable; low returns to IDLE and drops the count
//   TRIG_IN       trigger strobe; every high sample is one event
//   PERIOD_OUT    last completed interval in CLK cycles (holds between updates)
//   VALID_OUT     one-cycle pulse, PERIOD_OUT updated on the same edge
//   OVERFLOW_OUT  one-cycle pulse, interval saturated with no trigger
//   BUSY_OUT      high while an interval is being timed (MEASURE)
//
// All outputs are registered; there is no input-to-output combinational path.

module trigger_interval_meter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE_IN,
    input  logic             TRIG_IN,
    output logic [WIDTH-1:0] PERIOD_OUT,
    output logic             VALID_OUT,
    output logic             OVERFLOW_OUT,
    output logic             BUSY_OUT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] count;

    // The count register holds "edges since the opening trigger". At the edge
    // that samples the closing trigger it therefore equals t1 - t0 directly.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            count        <= '0;
            PERIOD_OUT   <= '0;
            VALID_OUT    <= 1'b0;
            OVERFLOW_OUT <= 1'b0;
            BUSY_OUT     <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            VALID_OUT    <= 1'b0;
            OVERFLOW_OUT <= 1'b0;

            if (!ENABLE_IN) begin
                // Disable beats any coincident trigger or overflow.
                state    <= IDLE;
                count    <= '0;
                BUSY_OUT <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end

                    ARMED: begin
                        if (TRIG_IN) begin
                            state    <= MEASURE;
                            count    <= CNT_ONE;
                            BUSY_OUT <= 1'b1;
                        end
                    end

                    MEASURE: begin
                        if (TRIG_IN) begin
                            // Trigger wins over saturation: a full-scale
                            // interval is still a valid measurement.
                            PERIOD_OUT <= count;
                            VALID_OUT  <= 1'b1;
                            count      <= CNT_ONE;
                        end else if (count == CNT_MAX) begin
                            OVERFLOW_OUT <= 1'b1;
                            count        <= '0;
                            state        <= ARMED;
                            BUSY_OUT     <= 1'b0;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        count    <= '0;
                        BUSY_OUT <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_interval_meter.sv
module tb_trigger_interval_meter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE_IN;
    logic        TRIG_IN;

    logic [15:0] period16;
    logic        valid16, ovf16, busy16;
    logic [3:0]  period4;
    logic        valid4, ovf4, busy4;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    trigger_interval_meter #(.WIDTH(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .ENABLE_IN(ENABLE_IN), .TRIG_IN(TRIG_IN),
        .PERIOD_OUT(period16), .VALID_OUT(valid16),
        .OVERFLOW_OUT(ovf16), .BUSY_OUT(busy16)
    );

    trigger_interval_meter #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .ENABLE_IN(ENABLE_IN), .TRIG_IN(TRIG_IN),
        .PERIOD_OUT(period4), .VALID_OUT(valid4),
        .OVERFLOW_OUT(ovf4), .BUSY_OUT(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive TRIG_IN for one edge; outputs are sampled 1 time unit after it.
    task automatic step(input logic t);
        TRIG_IN = t;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; ENABLE_IN = 1'b0; TRIG_IN = 1'b0;

        // Reset held with TRIG_IN toggling
        for (int i = 0; i < 4; i++) step(i[0]);
        chk("rst_period16", period16, 0);
        chk("rst_valid16",  valid16,  0);
        chk("rst_ovf16",    ovf16,    0);
        chk("rst_busy16",   busy16,   0);
        chk("rst_period4",  period4,  0);
        chk("rst_valid4",   valid4,   0);
        chk("rst_ovf4",     ovf4,     0);
        chk("rst_busy4",    busy4,    0);

        // Released, but disabled: triggers ignored
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            chk("dis_valid16", valid16, 0);
            chk("dis_busy16",  busy16,  0);
        end

        // Regular stream: 5 pulses 10 cycles apart
        ENABLE_IN = 1'b1;
        step(1'b0);                      // IDLE -> ARMED
        chk("arm_busy16", busy16, 0);
        for (int p = 0; p < 5; p++) begin
            step(1'b1);
            chk("str_valid16",  valid16,  (p == 0) ? 0 : 1);
            chk("str_period16", period16, (p == 0) ? 0 : 10);
            chk("str_busy16",   busy16,   1);
            for (int k = 0; k < 9; k++) begin
                step(1'b0);
                chk("str_gap_valid16", valid16, 0);
            end
        end

        // Continuous trigger for 6 cycles after re-arming
        ENABLE_IN = 1'b0;
        step(1'b0);
        chk("cont_dis_busy16", busy16, 0);
        ENABLE_IN = 1'b1;
        step(1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            chk("cont_valid16",  valid16,  (i == 0) ? 0 : 1);
            chk("cont_period16", period16, (i == 0) ? 10 : 1);
        end
        step(1'b0);
        chk("cont_end_valid16", valid16, 0);

        // Overflow on WIDTH=4: one trigger then silence
        ENABLE_IN = 1'b0;
        step(1'b0);
        ENABLE_IN = 1'b1;
        step(1'b0);                      // arm
        step(1'b1);                      // opening trigger
        chk("ovf_open_busy4", busy4, 1);
        chk("ovf_open_valid4", valid4, 0);
        for (int k = 0; k < 14; k++) begin
            step(1'b0);
            chk("ovf_wait_ovf4",  ovf4,  0);
            chk("ovf_wait_busy4", busy4, 1);
        end
        step(1'b0);                      // 15 edges after the trigger
        chk("ovf_pulse4",   ovf4,    1);
        chk("ovf_busy4",    busy4,   0);
        chk("ovf_period4",  period4, 1);
        chk("ovf_valid4",   valid4,  0);
        step(1'b0);
        chk("ovf_once4",    ovf4,    0);

        // After overflow: first trigger re-arms, next 3 cycles later measures
        step(1'b1);
        chk("rearm_valid4", valid4, 0);
        chk("rearm_busy4",  busy4,  1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("rearm_valid4b",  valid4,  1);
        chk("rearm_period4",  period4, 3);

        // Boundary: triggers exactly 15 cycles apart on WIDTH=4
        for (int k = 0; k < 14; k++) begin
            step(1'b0);
            chk("bnd_wait_ovf4", ovf4, 0);
        end
        step(1'b1);
        chk("bnd_valid4",  valid4,  1);
        chk("bnd_period4", period4, 15);
        chk("bnd_ovf4",    ovf4,    0);
        chk("bnd_busy4",   busy4,   1);
        step(1'b0);
        chk("bnd_post_ovf4", ovf4, 0);

        // Abort by disable mid-interval
        step(1'b1);
        step(1'b0); step(1'b0); step(1'b0);
        ENABLE_IN = 1'b0;
        step(1'b0);
        chk("ab_valid16", valid16, 0);
        chk("ab_busy16",  busy16,  0);
        chk("ab_busy4",   busy4,   0);
        ENABLE_IN = 1'b1;
        step(1'b0);                      // IDLE -> ARMED
        step(1'b1);                      // opens only
        chk("ab_rearm_valid16", valid16, 0);
        chk("ab_rearm_busy16",  busy16,  1);
        for (int k = 0; k < 4; k++) step(1'b0);
        step(1'b1);
        chk("ab_meas_valid16",  valid16,  1);
        chk("ab_meas_period16", period16, 5);
        chk("ab_meas_period4",  period4,  5);

        // Disable coincident with a trigger: disable wins
        step(1'b0); step(1'b0);
        ENABLE_IN = 1'b0;
        step(1'b1);
        chk("co_valid16",  valid16,  0);
        chk("co_busy16",   busy16,   0);
        chk("co_period16", period16, 5);

        // RESET asserted mid-interval (asynchronously)
        ENABLE_IN = 1'b1;
        step(1'b0);
        step(1'b1);
        step(1'b0); step(1'b0);
        chk("pre_rst_busy16", busy16, 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("mid_rst_busy16",   busy16,   0);
        chk("mid_rst_period16", period16, 0);
        chk("mid_rst_valid16",  valid16,  0);
        step(1'b1);
        RESET = 1'b0;
        step(1'b0);                      // IDLE -> ARMED
        step(1'b1);                      // opens only
        chk("post_rst_valid16", valid16, 0);
        for (int k = 0; k < 6; k++) step(1'b0);
        step(1'b1);
        chk("post_rst_valid16b",  valid16,  1);
        chk("post_rst_period16",  period16, 7);
        chk("post_rst_period4",   period4,  7);
        step(1'b0);
        chk("post_rst_pulse16", valid16, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/trigger_interval_meter.md
# trigger_interval_meter

Measures the number of CLK cycles between successive one-cycle trigger strobes, such as the TRIGG_OUT pulse of a cascaded counter stage. It is the receiving end of the trigger interface. It checks that a counter chain or divided-clock tick runs at the expected rate, and it feeds a measured period to display or compare logic. Each completed interval is published with a one-cycle valid strobe. A missing trigger is reported by an overflow strobe.

## Interface

- WIDTH, 16: width of the interval counter and PERIOD_OUT. Legal range is 2..32.
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE_IN  input  1  measurement enable, sampled synchronously; low forces IDLE.
- TRIG_IN  input  1  trigger strobe, sampled on each rising CLK; every high sample is one trigger event.
- PERIOD_OUT  output  WIDTH  last completed interval in CLK cycles; holds its value between updates.
- VALID_OUT  output  1  one-cycle pulse; PERIOD_OUT was updated on the same edge.
- OVERFLOW_OUT  output  1  one-cycle pulse; the interval reached 2^WIDTH-1 cycles with no trigger.
- BUSY_OUT  output  1  high while in MEASURE.

## Operation

- Reset values:
  - state = IDLE;
  - internal count = 0;
  - PERIOD_OUT = 0;
  - VALID_OUT = 0;
  - OVERFLOW_OUT = 0;
  - BUSY_OUT = 0.
- States are IDLE, ARMED and MEASURE. They are held in a registered FSM with a 2-bit encoding.
- In any state, ENABLE_IN low sends the next state to IDLE and clears the count. No VALID_OUT or OVERFLOW_OUT pulse is produced. PERIOD_OUT holds its value.
- IDLE: ENABLE_IN high -> ARMED. TRIG_IN is ignored in IDLE.
- ARMED: TRIG_IN high -> MEASURE with count = 1. No VALID_OUT, because the first trigger only opens an interval.
- MEASURE, TRIG_IN low:
  - count < 2^WIDTH-1: count increments by 1.
  - count = 2^WIDTH-1: OVERFLOW_OUT pulses, count is cleared, and the state goes to ARMED. PERIOD_OUT is unchanged.
- MEASURE, TRIG_IN high:
  - PERIOD_OUT <= count and VALID_OUT pulses.
  - count restarts at 1 and the state stays in MEASURE. Back-to-back intervals are therefore measured with no gap.
- Simultaneous events in MEASURE:
  - If TRIG_IN is high while count = 2^WIDTH-1, the trigger wins. PERIOD_OUT = 2^WIDTH-1, VALID_OUT pulses, and there is no overflow.
  - If ENABLE_IN is low in the same cycle as TRIG_IN, the disable wins and there is no VALID_OUT.
- TRIG_IN held high for N consecutive cycles in MEASURE gives N measurements of 1.
- Period definition: triggers sampled at edges t0 and t1 report t1 - t0. A free-running counter with COUNTER_MAX = M therefore reports M+1.
- Arithmetic is unsigned; the count never wraps.
- RESET asserted mid-interval discards the partial count immediately. After RESET is released, the block behaves as after power-on reset.

## Timing

- All outputs are registered.
- VALID_OUT and the new PERIOD_OUT are visible in the cycle after the edge that sampled the closing TRIG_IN, which is 1-cycle latency.
- OVERFLOW_OUT is visible in the cycle after the edge where the count was saturated with TRIG_IN low.
- BUSY_OUT follows the registered state. It goes high one cycle after the opening trigger is sampled and low one cycle after an overflow or disable.
- Interval range is 1..2^WIDTH-1 cycles.
- Throughput is one measurement per cycle at most.
- There is no combinational path from any input to any output.

## Test plan

- Reset and idle:
  - Assert RESET with TRIG_IN toggling.
  - Required: all outputs are 0, and no VALID_OUT occurs while ENABLE_IN is low.
- Regular stream, WIDTH=16:
  - ENABLE_IN high; TRIG_IN pulses every 10 cycles, 5 pulses.
  - Required: no VALID_OUT after the first pulse. Four VALID_OUT pulses follow, each with PERIOD_OUT = 10, each one cycle after its trigger.
- Continuous trigger:
  - TRIG_IN held high for 6 cycles after arming.
  - Required: 5 VALID_OUT pulses with PERIOD_OUT = 1.
- Overflow, WIDTH=4:
  - One trigger, then none.
  - Required: OVERFLOW_OUT pulses once, 15 cycles after the trigger edge. BUSY_OUT falls. PERIOD_OUT is unchanged.
  - Then triggers 3 cycles apart.
  - Required: the first pulse only re-arms; the next gives PERIOD_OUT = 3.
- Boundary, WIDTH=4:
  - Triggers exactly 15 cycles apart.
  - Required: PERIOD_OUT = 15, VALID_OUT pulses, and no OVERFLOW_OUT.
- Abort:
  - Drop ENABLE_IN mid-interval, or assert RESET mid-interval; in one case drop ENABLE_IN in the same cycle as a trigger.
  - Required: no VALID_OUT, and BUSY_OUT falls.
  - After re-enabling, the first trigger only arms and the next interval measures correctly.
